// File: rtl/banked_memory.sv
// Banked single-port memory with read-first responses and a whole-array clear sweep.
// The sweep also runs after every reset, so the array always comes up zeroed.
module banked_memory #(
    parameter  int DATA_W = 8,
    parameter  int BANKS  = 4,
    parameter  int DEPTH  = 1024,
    localparam int BANK_W = $clog2(BANKS),
    localparam int WORD_W = $clog2(DEPTH),
    localparam int ADDR_W = BANK_W + WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done
);

    // A single bank still needs a 1-bit select so the bank index is never zero-width.
    localparam int BSEL_W = (BANK_W > 0) ? BANK_W : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic                accept;
    logic [WORD_W-1:0]   word;
    logic [BSEL_W-1:0]   req_bank;
    logic [BSEL_W-1:0]   rsp_bank;
    logic                rsp_live;
    logic [DATA_W-1:0]   rd_data [BANKS];

    assign busy      = (state_q == CLEAR);
    assign req_ready = (state_q == IDLE) && !clr;
    assign accept    = req_valid && req_ready;
    assign word      = req_addr[WORD_W-1:0];

    if (BANK_W > 0) begin : g_sel
        assign req_bank = req_addr[ADDR_W-1 -: BANK_W];
    end else begin : g_nosel
        assign req_bank = '0;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == WORD_W'(DEPTH - 1)) begin
                    clr_done = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + WORD_W'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_live  <= 1'b0;
            rsp_bank  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_valid <= accept;
            if (accept) begin
                rsp_live <= 1'b1;
                rsp_bank <= req_bank;
            end
        end
    end

    // Each bank's read register only moves on a request to that bank, and rsp_bank
    // only moves on an accepted request, so the muxed output holds between responses.
    assign rsp_data = rsp_live ? rd_data[rsp_bank] : '0;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic              hit;
        logic              we;
        logic [WORD_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;

        assign hit   = accept && (req_bank == BSEL_W'(b));
        assign we    = busy || (hit && req_we);
        assign waddr = busy ? cnt_q : word;
        assign wdata = busy ? '0 : req_wdata;

        // NOTE: the array and its read register carry no reset so the tools can map them to block RAM.
        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (hit) begin
                rd_q <= mem[word];
            end
        end

        assign rd_data[b] = rd_q;
    end

endmodule

// File: tb/tb_banked_memory.sv
// Self-checking bench for banked_memory: a behavioural model checked every cycle,
// directed scenarios with literal expectations, random traffic, and a small-parameter instance.
module tb_banked_memory;

    localparam int DW = 8;
    localparam int DP = 1024;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_we, clr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_ready, rsp_valid, busy, clr_done;
    logic [DW-1:0] rsp_data;

    logic          rst2_n = 1'b0;
    logic          r2_valid, r2_we, clr2;
    logic [6:0]    r2_addr;
    logic [31:0]   r2_wdata;
    logic          r2_ready, rsp2_valid, busy2, clr2_done;
    logic [31:0]   rsp2_data;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    banked_memory dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .clr       (clr),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    banked_memory #(.DATA_W(32), .BANKS(8), .DEPTH(16)) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .req_valid (r2_valid),
        .req_ready (r2_ready),
        .req_we    (r2_we),
        .req_addr  (r2_addr),
        .req_wdata (r2_wdata),
        .rsp_valid (rsp2_valid),
        .rsp_data  (rsp2_data),
        .clr       (clr2),
        .busy      (busy2),
        .clr_done  (clr2_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a flat word array, a count of sweep cycles still to run, and the
    // expected response register.  The array is zeroed when a sweep completes.
    logic [DW-1:0] mm [1 << AW];
    int            sweep_left = 0;
    logic          exp_rv = 1'b0;
    logic [DW-1:0] exp_rd = '0;
    logic          m_acc;

    assign m_acc = req_valid && (sweep_left == 0) && !clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_left <= DP;
            exp_rv     <= 1'b0;
            exp_rd     <= '0;
        end else begin
            exp_rv <= m_acc;
            if (m_acc) begin
                exp_rd <= mm[req_addr];
                if (req_we) mm[req_addr] <= req_wdata;
            end
            if (sweep_left > 0) begin
                sweep_left <= sweep_left - 1;
                if (sweep_left == 1) begin
                    for (int i = 0; i < (1 << AW); i++) mm[i] <= '0;
                end
            end else if (clr) begin
                sweep_left <= DP;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",      64'(busy),      64'(sweep_left > 0));
            check("clr_done",  64'(clr_done),  64'(sweep_left == 1));
            check("req_ready", 64'(req_ready), 64'((sweep_left == 0) && !clr));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("rsp_data",  64'(rsp_data),  64'(exp_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 1'b0;
        req_we    = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_sweep(output int cyc, output int dones);
        cyc   = 0;
        dones = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            cyc++;
            if (clr_done === 1'b1) dones++;
            tick();
        end
    endtask

    task automatic rsp_is(input string name, input logic [DW-1:0] d);
        check({name, "_valid"}, 64'(rsp_valid), 64'(1));
        check({name, "_data"},  64'(rsp_data),  64'(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int cyc, dones;
        idle_in();
        req_addr  = '0;
        req_wdata = '0;
        r2_valid  = 1'b0;
        r2_we     = 1'b0;
        clr2      = 1'b0;
        r2_addr   = '0;
        r2_wdata  = '0;
        repeat (3) tick();
        cmp_en = 1'b1;
        check("reset_busy",      64'(busy),      64'(1));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_data",  64'(rsp_data),  64'(0));
        check("reset_clr_done",  64'(clr_done),  64'(0));
        check("reset_ready",     64'(req_ready), 64'(0));

        // Power-up sweep.
        rst_n = 1'b1;
        wait_sweep(cyc, dones);
        check("init_sweep_len",   64'(cyc),   64'(1024));
        check("init_sweep_dones", 64'(dones), 64'(1));
        check("ready_after_init", 64'(req_ready), 64'(1));
        req(1'b0, 12'hC05, '0);
        rsp_is("read_c05", 8'h00);

        // Bank independence.
        req(1'b1, 12'h003, 8'h5A);
        rsp_is("wr_003_prior", 8'h00);
        req(1'b1, 12'h403, 8'hA5);
        req(1'b0, 12'h003, '0);
        rsp_is("rd_003", 8'h5A);
        req(1'b0, 12'h403, '0);
        rsp_is("rd_403", 8'hA5);

        // Back-to-back writes are read-first.
        req(1'b1, 12'h7FF, 8'h11);
        req(1'b1, 12'h7FF, 8'h22);
        rsp_is("wr2_7ff_prior", 8'h11);
        req(1'b0, 12'h7FF, '0);
        rsp_is("rd_7ff", 8'h22);
        tick();
        check("hold_valid", 64'(rsp_valid), 64'(0));
        check("hold_data",  64'(rsp_data),  64'(8'h22));

        // clr together with a request: request is refused, sweep runs.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h003;
        req_wdata = 8'hFF;
        clr       = 1'b1;
        #1;
        check("clr_ready_low", 64'(req_ready), 64'(0));
        tick();
        idle_in();
        check("clr_busy_rise",  64'(busy),      64'(1));
        check("clr_no_accept",  64'(rsp_valid), 64'(0));
        clr = 1'b1;             // ignored while sweeping
        tick();
        clr = 1'b0;
        wait_sweep(cyc, dones);
        check("clr_sweep_len",   64'(cyc + 1), 64'(1024));
        check("clr_sweep_dones", 64'(dones),   64'(1));
        req(1'b0, 12'h003, '0);
        rsp_is("cleared_003", 8'h00);
        req(1'b0, 12'h403, '0);
        rsp_is("cleared_403", 8'h00);
        req(1'b0, 12'h7FF, '0);
        rsp_is("cleared_7ff", 8'h00);

        // Reset in the middle of a sweep.
        req(1'b1, 12'h123, 8'h77);
        req(1'b0, 12'h123, '0);
        rsp_is("rd_123", 8'h77);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (500) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_rsp_data",  64'(rsp_data),  64'(0));
        check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midreset_busy",      64'(busy),      64'(1));
        check("midreset_clr_done",  64'(clr_done),  64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        wait_sweep(cyc, dones);
        check("resweep_len",   64'(cyc),   64'(1024));
        check("resweep_dones", 64'(dones), 64'(1));
        req(1'b0, 12'h123, '0);
        rsp_is("cleared_123", 8'h00);

        // Random traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] bsel;
            logic [9:0] wsel;
            bsel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       wsel = 10'($urandom_range(0, 7));
                1:       wsel = 10'($urandom_range(1016, 1023));
                default: wsel = 10'($urandom);
            endcase
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = {bsel, wsel};
            req_wdata = 8'($urandom);
            clr       = ($urandom_range(0, 499) == 0);
            tick();
        end
        idle_in();
        tick();

        // Small-parameter instance.
        rst2_n = 1'b1;
        cyc = 0;
        while (busy2 === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        check("p2_sweep_len", 64'(cyc),      64'(16));
        check("p2_ready",     64'(r2_ready), 64'(1));
        r2_valid = 1'b1;
        r2_we    = 1'b1;
        r2_addr  = 7'h7F;
        r2_wdata = 32'hDEADBEEF;
        tick();
        check("p2_wr_prior", 64'(rsp2_data), 64'(0));
        r2_we = 1'b0;
        tick();
        r2_valid = 1'b0;
        check("p2_rd_valid", 64'(rsp2_valid), 64'(1));
        check("p2_rd_data",  64'(rsp2_data),  64'(32'hDEADBEEF));

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_memory.md
BANKED_MEMORY -- requirements
Module: banked_memory

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, 1 to 64.
REQ-002 Parameter BANKS, default 4: bank count, power of two, 1 to 16.
REQ-003 Parameter DEPTH, default 1024: words per bank, power of two, at least 2.
REQ-004 Parameter ADDR_W, derived as log2(BANKS)+log2(DEPTH): request address width; upper log2(BANKS) bits select the bank, lower log2(DEPTH) bits select the word.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present this cycle.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  bank-select and word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  rsp_data holds the result of the previous accepted request.
REQ-013 rsp_data  output  DATA_W  prior content of the addressed word.
REQ-014 clr  input  1  single-cycle request to zero the entire array.
REQ-015 busy  output  1  clear sweep in progress.
REQ-016 clr_done  output  1  one-cycle pulse on the final cycle of a clear sweep.

Function
REQ-017 The controller SHALL have exactly two states, IDLE and CLEAR, held in a register.
REQ-018 req_ready SHALL be 1 only when the state is IDLE and clr is 0.
REQ-019 busy SHALL be 1 exactly when the state is CLEAR.
REQ-020 A request SHALL be accepted only on a cycle where req_valid and req_ready are both 1; req_valid without req_ready SHALL have no effect.
REQ-021 An accepted write SHALL store req_wdata at word req_addr[log2(DEPTH)-1:0] of the bank selected by req_addr[ADDR_W-1:log2(DEPTH)] at the end of that cycle.
REQ-022 Every accepted request, read or write, SHALL produce rsp_valid=1 on the following cycle, with rsp_data equal to the addressed word's content before that cycle's write (read-first).
REQ-023 rsp_valid SHALL be 0 in any cycle that does not follow an accepted request.
REQ-024 rsp_data SHALL hold its last value while rsp_valid is 0.
REQ-025 Latency SHALL be one cycle, and throughput SHALL be one request per cycle in IDLE.
REQ-026 Back-to-back write then read of the same address SHALL return the newly written data.
REQ-027 In IDLE, clr=1 SHALL move the state to CLEAR on the next cycle and load the sweep counter with 0; a request presented in the same cycle SHALL NOT be accepted.
REQ-028 In CLEAR, each cycle SHALL write 0 to word index = sweep counter in all BANKS banks in parallel, then increment the counter.
REQ-029 A sweep SHALL last exactly DEPTH cycles.
REQ-030 clr_done SHALL pulse on the cycle the word at index DEPTH-1 is cleared; the state SHALL be IDLE on the next cycle.
REQ-031 clr asserted while in CLEAR SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-032 The sweep counter SHALL be log2(DEPTH) bits wide and SHALL NOT wrap during a sweep.
REQ-033 The storage SHALL be per-bank synchronous arrays with no reset on the contents, so that they infer block RAM.

Reset
REQ-034 While rst_n is 0, the block SHALL immediately force state=CLEAR, sweep counter=0, rsp_valid=0, rsp_data=0 and clr_done=0.
REQ-035 After rst_n deasserts, the block SHALL perform a full clear sweep, so that the array reads as all zeros once busy falls.
REQ-036 Reset asserted mid-sweep or mid-request SHALL abort the operation; no pending response SHALL appear after reset.

Verification
REQ-037 Reset release (defaults): busy=1 for 1024 cycles; clr_done pulses once; then req_ready=1; a read of addr 0xC05 gives rsp_valid=1 with rsp_data=0x00 one cycle later.
REQ-038 Write 0x5A to 0x003 and 0xA5 to 0x403, then read both: responses 0x5A and 0xA5, confirming banks are independent.
REQ-039 Write 0x11 to 0x7FF, then write 0x22 to 0x7FF on the next cycle: the second response is 0x11 (read-first), and a following read gives 0x22.
REQ-040 Assert clr together with req_valid: req_ready=0, the request is not accepted, busy rises next cycle, and after 1024 cycles all previously written words read 0x00.
REQ-041 Pull rst_n low at sweep cycle 500: outputs go to reset values at once, and a full 1024-cycle sweep restarts after release.
REQ-042 Parameter sweep DATA_W=32, BANKS=8, DEPTH=16: sweep lasts 16 cycles, and a write/read of 0xDEADBEEF at 0x7F round-trips.
